// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core pipeline: widths, memory-stage
// state encoding, execute opcodes and small address helpers.
package mips_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    // Memory-access stage state encoding
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } mem_state_t;

    // Execute-stage operation codes
    localparam logic [3:0] EXE_ADD = 4'd0;
    localparam logic [3:0] EXE_SUB = 4'd1;
    localparam logic [3:0] EXE_AND = 4'd2;
    localparam logic [3:0] EXE_OR  = 4'd3;
    localparam logic [3:0] EXE_XOR = 4'd4;
    localparam logic [3:0] EXE_NOR = 4'd5;
    localparam logic [3:0] EXE_SLT = 4'd6;
    localparam logic [3:0] EXE_SLL = 4'd7;
    localparam logic [3:0] EXE_SRL = 4'd8;
    localparam logic [3:0] EXE_SRA = 4'd9;
    localparam logic [3:0] EXE_LUI = 4'd10;

    // True when a byte address points at the start of a 32-bit word
    function automatic logic word_aligned(input logic [WORD_W-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

    // Register $zero is hard-wired, so writes to it are always suppressed
    function automatic logic reg_writable(input logic [REG_W-1:0] r, input logic en);
        return en && (r != 5'd0);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts ACCESS cycles spent waiting for dmem_ready and flags the last
// allowed cycle before the transaction is declared a bus error.
module mem_wait_timer #(
    parameter int WAIT_MAX = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [7:0] LAST_COUNT = 8'(WAIT_MAX - 1);

    logic [7:0] count_r;

    // Wait counter: cleared outside ACCESS, counts up while waiting, holds at the last value
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= 8'd0;
        end else if (clear) begin
            count_r <= 8'd0;
        end else if (enable && (count_r != LAST_COUNT)) begin
            count_r <= count_r + 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign terminal = enable && (count_r == LAST_COUNT);

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: runs LW/SW on the ready-handshaked data port, stalls
// execute while a transaction is outstanding and emits one registered
// writeback record per accepted instruction.
module mem_access_stage
    import mips_pkg::*;
#(
    parameter int WAIT_MAX = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [REG_W-1:0]  ex_write_r,
    input  logic              ex_write_en,
    input  logic [WORD_W-1:0] ex_write_data,
    input  logic              ex_read_mm,
    input  logic              ex_write_mm,
    input  logic [WORD_W-1:0] ex_mm_addr,
    input  logic [WORD_W-1:0] ex_store_data,
    output logic              mem_busy,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [WORD_W-1:0] dmem_addr,
    output logic [WORD_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic [WORD_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic [REG_W-1:0]  wb_r,
    output logic              wb_en,
    output logic [WORD_W-1:0] wb_data,
    output logic              addr_err,
    output logic              bus_err
);

    mem_state_t        state_r;
    logic              mem_busy_r;
    logic              dmem_req_r;
    logic              dmem_we_r;
    logic [WORD_W-1:0] dmem_addr_r;
    logic [WORD_W-1:0] dmem_wdata_r;
    logic [REG_W-1:0]  lat_r_r;
    logic              lat_en_r;
    logic              wb_valid_r;
    logic [REG_W-1:0]  wb_r_r;
    logic              wb_en_r;
    logic [WORD_W-1:0] wb_data_r;
    logic              addr_err_r;
    logic              bus_err_r;

    logic              timer_clear_s;
    logic              timer_enable_s;
    logic              timeout_s;
    logic              is_mem_op_s;
    logic              mem_op_ok_s;

    // Decode of the instruction offered by execute
    always_comb begin
        is_mem_op_s = ex_read_mm || ex_write_mm;
        mem_op_ok_s = (ex_read_mm ^ ex_write_mm) && word_aligned(ex_mm_addr);
    end

    // The timer only runs during ACCESS and is held at zero otherwise
    always_comb begin
        timer_clear_s  = (state_r == ST_IDLE);
        timer_enable_s = (state_r == ST_ACCESS);
    end

    mem_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (timer_clear_s),
        .enable   (timer_enable_s),
        .terminal (timeout_s)
    );

    // Stage FSM with transaction latches and registered writeback record
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            mem_busy_r   <= 1'b0;
            dmem_req_r   <= 1'b0;
            dmem_we_r    <= 1'b0;
            dmem_addr_r  <= 32'd0;
            dmem_wdata_r <= 32'd0;
            lat_r_r      <= 5'd0;
            lat_en_r     <= 1'b0;
            wb_valid_r   <= 1'b0;
            wb_r_r       <= 5'd0;
            wb_en_r      <= 1'b0;
            wb_data_r    <= 32'd0;
            addr_err_r   <= 1'b0;
            bus_err_r    <= 1'b0;
        end else begin
            // Pulses default low; the branches below raise them for one cycle
            wb_valid_r <= 1'b0;
            addr_err_r <= 1'b0;
            bus_err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (ex_valid && !is_mem_op_s) begin
                        wb_valid_r <= 1'b1;
                        wb_r_r     <= ex_write_r;
                        wb_en_r    <= reg_writable(ex_write_r, ex_write_en);
                        wb_data_r  <= ex_write_data;
                    end else if (ex_valid && mem_op_ok_s) begin
                        state_r      <= ST_ACCESS;
                        mem_busy_r   <= 1'b1;
                        dmem_req_r   <= 1'b1;
                        dmem_we_r    <= ex_write_mm;
                        dmem_addr_r  <= ex_mm_addr;
                        dmem_wdata_r <= ex_store_data;
                        lat_r_r      <= ex_write_r;
                        lat_en_r     <= ex_write_en;
                    end else if (ex_valid) begin
                        // Misaligned or contradictory memory op: report, never touch the bus
                        wb_valid_r <= 1'b1;
                        wb_r_r     <= ex_write_r;
                        wb_en_r    <= 1'b0;
                        wb_data_r  <= ex_mm_addr;
                        addr_err_r <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (dmem_ready) begin
                        // Ready takes priority over a timeout in the same cycle
                        state_r    <= ST_IDLE;
                        mem_busy_r <= 1'b0;
                        dmem_req_r <= 1'b0;
                        dmem_we_r  <= 1'b0;
                        wb_valid_r <= 1'b1;
                        wb_r_r     <= lat_r_r;
                        if (dmem_we_r) begin
                            wb_en_r   <= 1'b0;
                            wb_data_r <= dmem_addr_r;
                        end else begin
                            wb_en_r   <= reg_writable(lat_r_r, lat_en_r);
                            wb_data_r <= dmem_rdata;
                        end
                    end else if (timeout_s) begin
                        state_r    <= ST_IDLE;
                        mem_busy_r <= 1'b0;
                        dmem_req_r <= 1'b0;
                        dmem_we_r  <= 1'b0;
                        wb_valid_r <= 1'b1;
                        wb_r_r     <= lat_r_r;
                        wb_en_r    <= 1'b0;
                        wb_data_r  <= dmem_addr_r;
                        bus_err_r  <= 1'b1;
                    end else begin
                        state_r <= ST_ACCESS;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    mem_busy_r <= 1'b0;
                    dmem_req_r <= 1'b0;
                    dmem_we_r  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_busy   = mem_busy_r;
    assign dmem_req   = dmem_req_r;
    assign dmem_we    = dmem_we_r;
    assign dmem_addr  = dmem_addr_r;
    assign dmem_wdata = dmem_wdata_r;
    assign wb_valid   = wb_valid_r;
    assign wb_r       = wb_r_r;
    assign wb_en      = wb_en_r;
    assign wb_data    = wb_data_r;
    assign addr_err   = addr_err_r;
    assign bus_err    = bus_err_r;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: table of directed records,
// hand-written reset/stall sequences and a randomized run against a
// transaction-level reference model.
module tb_mem_access_stage;

    localparam int WAIT_MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [4:0]  ex_write_r;
    logic        ex_write_en;
    logic [31:0] ex_write_data;
    logic        ex_read_mm;
    logic        ex_write_mm;
    logic [31:0] ex_mm_addr;
    logic [31:0] ex_store_data;
    logic        mem_busy;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_r;
    logic        wb_en;
    logic [31:0] wb_data;
    logic        addr_err;
    logic        bus_err;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_stage #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_write_r(ex_write_r), .ex_write_en(ex_write_en),
        .ex_write_data(ex_write_data), .ex_read_mm(ex_read_mm), .ex_write_mm(ex_write_mm),
        .ex_mm_addr(ex_mm_addr), .ex_store_data(ex_store_data),
        .mem_busy(mem_busy), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_r(wb_r), .wb_en(wb_en), .wb_data(wb_data),
        .addr_err(addr_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  r;
        logic        en;
        logic [31:0] wdata;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] sdata;
        int          d;      // non-ready ACCESS cycles before dmem_ready
        logic [31:0] rdata;
    } txn_t;

    typedef struct {
        logic        en;
        logic [31:0] data;
        logic        aerr;
        logic        berr;
        int          busy;   // cycles with mem_busy/dmem_req high
    } exp_t;

    typedef struct {
        txn_t t;
        exp_t e;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference model: what one instruction should produce, from the stage's rules
    function automatic exp_t model(input txn_t t);
        exp_t e;
        e.aerr = 1'b0;
        e.berr = 1'b0;
        e.busy = 0;
        if (!t.rd && !t.wr) begin
            e.en   = t.en && (t.r != 5'd0);
            e.data = t.wdata;
        end else if ((t.rd && t.wr) || (t.addr % 4 != 0)) begin
            e.en   = 1'b0;
            e.data = t.addr;
            e.aerr = 1'b1;
        end else if (t.d < WAIT_MAX) begin
            e.busy = t.d + 1;
            e.en   = t.rd ? (t.en && (t.r != 5'd0)) : 1'b0;
            e.data = t.rd ? t.rdata : t.addr;
        end else begin
            e.busy = WAIT_MAX;
            e.en   = 1'b0;
            e.data = 32'd0;
            e.berr = 1'b1;
        end
        return e;
    endfunction

    // Offer one instruction, serve the memory side, then check the record
    task automatic run_txn(input txn_t t, input exp_t e, input string tag);
        int nbusy;
        int c;
        ex_valid      = 1'b1;
        ex_write_r    = t.r;
        ex_write_en   = t.en;
        ex_write_data = t.wdata;
        ex_read_mm    = t.rd;
        ex_write_mm   = t.wr;
        ex_mm_addr    = t.addr;
        ex_store_data = t.sdata;
        dmem_ready    = 1'b0;
        tick();
        ex_valid = 1'b0;
        nbusy = 0;
        c = 0;
        while ((mem_busy || dmem_req) && c < WAIT_MAX + 4) begin
            chk({tag, ".req_eq_busy"}, {31'd0, dmem_req}, {31'd0, mem_busy});
            chk({tag, ".dmem_addr"}, dmem_addr, t.addr);
            chk({tag, ".dmem_we"}, {31'd0, dmem_we}, {31'd0, t.wr});
            if (t.wr) chk({tag, ".dmem_wdata"}, dmem_wdata, t.sdata);
            chk({tag, ".wb_valid_busy"}, {31'd0, wb_valid}, 32'd0);
            if (c == t.d) begin
                dmem_ready = 1'b1;
                dmem_rdata = t.rdata;
            end else begin
                dmem_ready = 1'b0;
                dmem_rdata = $urandom;
            end
            nbusy++;
            c++;
            tick();
        end
        dmem_ready = 1'b0;
        chk({tag, ".busy_cycles"}, nbusy, e.busy);
        chk({tag, ".wb_valid"}, {31'd0, wb_valid}, 32'd1);
        chk({tag, ".wb_r"}, {27'd0, wb_r}, {27'd0, t.r});
        chk({tag, ".wb_en"}, {31'd0, wb_en}, {31'd0, e.en});
        chk({tag, ".addr_err"}, {31'd0, addr_err}, {31'd0, e.aerr});
        chk({tag, ".bus_err"}, {31'd0, bus_err}, {31'd0, e.berr});
        if (!e.berr) chk({tag, ".wb_data"}, wb_data, e.data);
        tick();
        chk({tag, ".pulse_end"}, {29'd0, wb_valid, addr_err, bus_err}, 32'd0);
    endtask

    vec_t vecs[11];

    initial begin
        txn_t t;
        exp_t e;
        int   op;

        rst = 1'b1;
        ex_valid = 1'b0; ex_write_r = 5'd0; ex_write_en = 1'b0; ex_write_data = 32'd0;
        ex_read_mm = 1'b0; ex_write_mm = 1'b0; ex_mm_addr = 32'd0; ex_store_data = 32'd0;
        dmem_ready = 1'b0; dmem_rdata = 32'd0;
        tick();
        tick();
        chk("reset.flags", {25'd0, mem_busy, dmem_req, dmem_we, wb_valid, wb_en, addr_err, bus_err}, 32'd0);
        chk("reset.dmem_addr", dmem_addr, 32'd0);
        chk("reset.dmem_wdata", dmem_wdata, 32'd0);
        chk("reset.wb_data", wb_data, 32'd0);
        chk("reset.wb_r", {27'd0, wb_r}, 32'd0);
        rst = 1'b0;
        tick();

        //           r     en    wdata          rd    wr    addr           sdata          d   rdata             en    data           aerr  berr  busy
        vecs[0]  = '{'{5'd3,  1'b1, 32'h0000_1234, 1'b0, 1'b0, 32'h0000_0000, 32'h0,         0,  32'h0},         '{1'b1, 32'h0000_1234, 1'b0, 1'b0, 0}};
        vecs[1]  = '{'{5'd0,  1'b1, 32'h0000_0055, 1'b0, 1'b0, 32'h0000_0000, 32'h0,         0,  32'h0},         '{1'b0, 32'h0000_0055, 1'b0, 1'b0, 0}};
        vecs[2]  = '{'{5'd7,  1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 32'h0,         0,  32'h0},         '{1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 0}};
        vecs[3]  = '{'{5'd9,  1'b1, 32'h0,         1'b1, 1'b0, 32'h0000_0102, 32'h0,         0,  32'h0},         '{1'b0, 32'h0000_0102, 1'b1, 1'b0, 0}};
        vecs[4]  = '{'{5'd10, 1'b1, 32'h0,         1'b1, 1'b1, 32'h0000_0040, 32'h0,         0,  32'h0},         '{1'b0, 32'h0000_0040, 1'b1, 1'b0, 0}};
        vecs[5]  = '{'{5'd11, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0203, 32'h1,         0,  32'h0},         '{1'b0, 32'h0000_0203, 1'b1, 1'b0, 0}};
        vecs[6]  = '{'{5'd12, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0200, 32'hA5A5_A5A5, 0,  32'h0},         '{1'b0, 32'h0000_0200, 1'b0, 1'b0, 1}};
        vecs[7]  = '{'{5'd8,  1'b1, 32'h0,         1'b1, 1'b0, 32'h0000_0100, 32'h0,         2,  32'hDEAD_BEEF}, '{1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 3}};
        vecs[8]  = '{'{5'd0,  1'b1, 32'h0,         1'b1, 1'b0, 32'h0000_0104, 32'h0,         1,  32'h1111_2222}, '{1'b0, 32'h1111_2222, 1'b0, 1'b0, 2}};
        vecs[9]  = '{'{5'd13, 1'b1, 32'h0,         1'b1, 1'b0, 32'h0000_0108, 32'h0,         99, 32'h0},         '{1'b0, 32'h0,         1'b0, 1'b1, 4}};
        vecs[10] = '{'{5'd14, 1'b1, 32'h0,         1'b1, 1'b0, 32'h0000_010C, 32'h0,         3,  32'hCAFE_F00D}, '{1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 4}};

        for (int i = 0; i < 11; i++) begin
            run_txn(vecs[i].t, vecs[i].e, $sformatf("vec%0d", i));
        end

        // Reset in the middle of a wait abandons the load; a late ready is ignored
        ex_valid = 1'b1; ex_write_r = 5'd6; ex_write_en = 1'b1;
        ex_read_mm = 1'b1; ex_write_mm = 1'b0; ex_mm_addr = 32'h0000_0400;
        tick();
        ex_valid = 1'b0;
        chk("rstmid.busy_before", {31'd0, mem_busy}, 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid.flags", {25'd0, mem_busy, dmem_req, dmem_we, wb_valid, wb_en, addr_err, bus_err}, 32'd0);
        chk("rstmid.dmem_addr", dmem_addr, 32'd0);
        chk("rstmid.wb_data", wb_data, 32'd0);
        dmem_ready = 1'b1; dmem_rdata = 32'h5555_AAAA;
        tick();
        chk("rstmid.late_ready", {30'd0, wb_valid, dmem_req}, 32'd0);
        tick();
        chk("rstmid.idle_ready", {29'd0, wb_valid, mem_busy, dmem_req}, 32'd0);
        dmem_ready = 1'b0;

        // Execute inputs are ignored while the stage is busy
        ex_valid = 1'b1; ex_write_r = 5'd4; ex_write_en = 1'b1;
        ex_read_mm = 1'b1; ex_write_mm = 1'b0; ex_mm_addr = 32'h0000_0300;
        tick();
        ex_write_r = 5'd5; ex_read_mm = 1'b0; ex_write_data = 32'h0000_0999;
        chk("stall.busy1", {31'd0, mem_busy}, 32'd1);
        tick();
        chk("stall.busy2", {30'd0, mem_busy, wb_valid}, 32'd2);
        dmem_ready = 1'b1; dmem_rdata = 32'h0000_0077;
        tick();
        ex_valid = 1'b0; dmem_ready = 1'b0;
        chk("stall.wb", {26'd0, wb_valid, wb_r}, {26'd0, 1'b1, 5'd4});
        chk("stall.wb_data", wb_data, 32'h0000_0077);
        tick();
        chk("stall.no_extra", {31'd0, wb_valid}, 32'd0);

        // Randomized run against the reference model
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 3);
            t.r     = 5'($urandom_range(0, 31));
            t.en    = 1'($urandom_range(0, 1));
            t.wdata = $urandom;
            t.sdata = $urandom;
            t.rdata = $urandom;
            t.addr  = $urandom & 32'hFFFF_FFFC;
            t.d     = $urandom_range(0, WAIT_MAX + 1);
            t.rd    = (op == 1);
            t.wr    = (op == 2);
            if (op == 3) begin
                if ($urandom_range(0, 1) == 0) begin
                    t.rd   = 1'b1;
                    t.wr   = 1'b1;
                end else begin
                    t.rd   = 1'($urandom_range(0, 1));
                    t.wr   = !t.rd;
                    t.addr = t.addr | 32'($urandom_range(1, 3));
                end
            end
            e = model(t);
            run_txn(t, e, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
